// File: rtl/seg_capture_decoder.sv
// Passive decoder for a two-digit multiplexed common-anode seven-segment bus.
// Latency: pins stable from edge k are reflected on outputs after edge k+STABLE_CYCLES+3.
// Backpressure: none; observe-only, outputs are status registers and a one-cycle update pulse.
module seg_capture_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic [1:0] an_in,
  input  logic       clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [1:0] digit_valid,
  output logic       update,
  output logic       bad_pattern,
  output logic [6:0] bad_seg
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_HIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HOLD   = 1'b1;

  // Returns {legal, value}; blank and garbage both decode as not legal.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0;
    case (seg)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0011000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  logic [8:0]          sync_a, samp, samp_prev;
  logic                changed;
  logic [CW-1:0]       cnt;
  logic [0:0]          state;
  logic                cmt_vld;
  logic [8:0]          cmt_dat;
  logic [1:0]          an_sel, sel;
  logic [4:0]          dec;
  logic [1:0][3:0]     digit_q, digit_nxt;
  logic [1:0]          valid_q, valid_nxt;
  logic [1:0][TW-1:0]  tcnt, tcnt_nxt;
  logic                bad_nxt, upd_nxt;
  logic [6:0]          bad_seg_nxt;

  assign changed = (samp != samp_prev);
  assign an_sel  = ~cmt_dat[8:7];
  assign sel     = cmt_vld ? {an_sel == 2'b10, an_sel == 2'b01} : 2'b00;
  assign dec     = seg_decode(cmt_dat[6:0]);

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit_valid = valid_q;

  // Two-flop synchronizer plus one-sample history; idle bus (all ones) after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a    <= '1;
      samp      <= '1;
      samp_prev <= '1;
    end else begin
      sync_a    <= {an_in, seg_in};
      samp      <= sync_a;
      samp_prev <= samp;
    end
  end

  // Stability counter and SETTLE/HOLD FSM; one commit request per stable run.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      state   <= ST_SETTLE;
      cmt_vld <= 1'b0;
      cmt_dat <= '1;
    end else begin
      cmt_vld <= (state == ST_SETTLE) && (cnt == CNT_MAX);
      // samp_prev is still inside the stable run even if samp changes this cycle
      cmt_dat <= samp_prev;
      if (changed) begin
        cnt   <= CW'(1);
        state <= ST_SETTLE;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        if (state == ST_SETTLE && cnt == CNT_MAX) state <= ST_HOLD;
      end
    end
  end

  // Commit/timeout resolution per digit; a commit beats a timeout on the same digit.
  always_comb begin
    digit_nxt   = digit_q;
    valid_nxt   = valid_q;
    tcnt_nxt    = tcnt;
    bad_nxt     = bad_pattern;
    bad_seg_nxt = bad_seg;
    if (clear) bad_nxt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (sel[i]) begin
        tcnt_nxt[i] = '0;
        if (dec[4]) begin
          digit_nxt[i] = dec[3:0];
          valid_nxt[i] = 1'b1;
        end else begin
          valid_nxt[i] = 1'b0;
          if (cmt_dat[6:0] != 7'h7f) begin
            bad_nxt     = 1'b1;
            bad_seg_nxt = cmt_dat[6:0];
          end
        end
      end else begin
        if (tcnt[i] != TMO_MAX) tcnt_nxt[i] = tcnt[i] + TW'(1);
        if (valid_q[i] && tcnt[i] == TMO_HIT) valid_nxt[i] = 1'b0;
      end
    end
    upd_nxt = (digit_nxt != digit_q) || (valid_nxt != valid_q);
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q     <= '0;
      valid_q     <= '0;
      tcnt        <= '0;
      bad_pattern <= 1'b0;
      bad_seg     <= '0;
      update      <= 1'b0;
    end else begin
      digit_q     <= digit_nxt;
      valid_q     <= valid_nxt;
      tcnt        <= tcnt_nxt;
      bad_pattern <= bad_nxt;
      bad_seg     <= bad_seg_nxt;
      update      <= upd_nxt;
    end
  end

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Bench for seg_capture_decoder: randomized and directed bus patterns against a run-length model.
// Expected output changes are queued per cycle and popped by a negedge monitor.
// No backpressure on the DUT; the bench only drives pins, reset and clear.
module tb_seg_capture_decoder;

  localparam int S   = 4;
  localparam int TMO = 50;

  logic       clk;
  logic       reset;
  logic [6:0] seg_in;
  logic [1:0] an_in;
  logic       clear;
  logic [3:0] digit0, digit1;
  logic [1:0] digit_valid;
  logic       update, bad_pattern;
  logic [6:0] bad_seg;

  seg_capture_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .an_in(an_in), .clear(clear),
    .digit0(digit0), .digit1(digit1), .digit_valid(digit_valid), .update(update),
    .bad_pattern(bad_pattern), .bad_seg(bad_seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cyc;
    logic [17:0] outs;
    logic        upd;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a pin run that lasts S edges is committed once, 4 edges after its S-th edge.
  logic [8:0]      prev_pin;
  int              run_len;
  bit              done;
  int              due_q[$];
  logic [8:0]      pin_q[$];
  logic [1:0][3:0] m_digit;
  logic [1:0]      m_valid;
  logic            m_bad;
  logic [6:0]      m_bseg;
  int              last_commit [2];

  task automatic model_step();
    logic [8:0]      p, cp;
    logic [1:0][3:0] o_digit;
    logic [1:0]      o_valid;
    logic            o_bad, upd;
    logic [6:0]      o_bseg;
    int              cd, val;
    rec_t            r;
    cyc++;
    o_digit = m_digit; o_valid = m_valid; o_bad = m_bad; o_bseg = m_bseg;
    upd = 1'b0;
    if (reset) begin
      prev_pin = '1; run_len = 0; done = 0;
      due_q.delete(); pin_q.delete();
      m_digit = '0; m_valid = '0; m_bad = 1'b0; m_bseg = '0;
      last_commit[0] = cyc; last_commit[1] = cyc;
    end else begin
      p = {an_in, seg_in};
      if (p != prev_pin) begin
        prev_pin = p; run_len = 1; done = 0;
      end else begin
        run_len++;
      end
      if (!done && run_len >= S) begin
        done = 1;
        due_q.push_back(cyc + 4);
        pin_q.push_back(p);
      end
      if (clear) m_bad = 1'b0;
      cd = -1;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        cp = pin_q.pop_front();
        if (cp[8:7] == 2'b10) cd = 0;
        else if (cp[8:7] == 2'b01) cd = 1;
        if (cd >= 0) begin
          last_commit[cd] = cyc;
          val = -1;
          for (int v = 0; v < 16; v++) if (seg_tab[v] == cp[6:0]) val = v;
          if (val >= 0) begin
            m_digit[cd] = 4'(val);
            m_valid[cd] = 1'b1;
          end else begin
            m_valid[cd] = 1'b0;
            if (cp[6:0] != 7'h7f) begin
              m_bad = 1'b1; m_bseg = cp[6:0];
            end
          end
        end
      end
      for (int d = 0; d < 2; d++)
        if (d != cd && m_valid[d] && (cyc - last_commit[d]) == TMO) m_valid[d] = 1'b0;
      upd = (m_digit != o_digit) || (m_valid != o_valid);
    end
    if (upd || m_digit != o_digit || m_valid != o_valid || m_bad != o_bad || m_bseg != o_bseg) begin
      r.cyc  = cyc;
      r.outs = {m_digit[0], m_digit[1], m_valid, m_bad, m_bseg};
      r.upd  = upd;
      exp_q.push_back(r);
    end
  endtask

  initial begin
    prev_pin = '1; run_len = 0; done = 0;
    m_digit = '0; m_valid = '0; m_bad = 1'b0; m_bseg = '0;
    last_commit[0] = 0; last_commit[1] = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: any visible output change or update pulse must match the next queued expectation.
  initial begin
    logic [17:0] cur, mon_prev;
    rec_t        e;
    mon_prev = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cur = {digit0, digit1, digit_valid, bad_pattern, bad_seg};
      if (cur !== mon_prev || update !== 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_change at cycle %0d: got outs %0h update %b, expected no change",
                   cyc, cur, update);
        end else begin
          e = exp_q.pop_front();
          check("change_cycle", cyc, e.cyc);
          check("outputs", 32'(cur), 32'(e.outs));
          check("update", 32'(update), 32'(e.upd));
        end
      end
      mon_prev = cur;
    end
  end

  task automatic hold(input logic [1:0] a, input logic [6:0] sg, input int n);
    an_in = a; seg_in = sg;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_outputs", 32'({digit0, digit1, digit_valid, update, bad_pattern, bad_seg}), 32'd0);
  endtask

  initial begin
    logic [1:0] a;
    logic [6:0] sg;
    int         k;
    reset = 1'b1; an_in = 2'b11; seg_in = 7'h7f; clear = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_reset();

    // Digit0 = 3 appears S+3 edges after the pins settle, once.
    hold(2'b10, 7'b0110000, 20);
    // Multiplexed 5 / E, repeated commits of identical values.
    for (int i = 0; i < 3; i++) begin
      hold(2'b10, 7'b0010010, 20);
      hold(2'b01, 7'b0000110, 20);
    end
    // Short glitch of 4 must never commit.
    hold(2'b10, 7'b0011001, 3);
    hold(2'b10, 7'b1111001, 15);
    // Illegal pattern, clear on idle bus, then blank.
    hold(2'b01, 7'b1010101, 15);
    hold(2'b11, 7'h7f, 5);
    pulse_clear();
    hold(2'b11, 7'h7f, 3);
    hold(2'b01, 7'h7f, 15);
    // Clear coincident with a bad commit: bad_pattern stays set, bad_seg updates.
    hold(2'b10, 7'b0101010, 7);
    clear = 1'b1;
    hold(2'b10, 7'b0101010, 1);
    clear = 1'b0;
    hold(2'b10, 7'b0101010, 5);
    pulse_clear();
    // Timeout after commit of A.
    hold(2'b10, 7'b0001000, 12);
    hold(2'b11, 7'h7f, 70);
    // Reset in the middle of a settle.
    hold(2'b01, 7'b0000011, 3);
    do_reset();
    hold(2'b01, 7'b0000011, 15);
    // Reset while holding with both digits valid.
    hold(2'b10, 7'b1000110, 20);
    hold(2'b01, 7'b0100001, 20);
    do_reset();
    hold(2'b01, 7'b0100001, 15);

    // Randomized bus traffic.
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      a = (k < 4) ? 2'b10 : (k < 8) ? 2'b01 : (k == 8) ? 2'b11 : 2'b00;
      k = $urandom_range(0, 19);
      if (k < 12)      sg = seg_tab[$urandom_range(0, 15)];
      else if (k < 15) sg = 7'h7f;
      else             sg = 7'($urandom_range(0, 127));
      hold(a, sg, $urandom_range(1, 30));
      if ($urandom_range(0, 9) == 0) pulse_clear();
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    hold(2'b11, 7'h7f, S + 10);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_capture_decoder.md
Name: seg_capture_decoder

Overview:
- Observer at the far end of the two-digit multiplexed common-anode seven-segment bus. Samples segment and anode lines and waits for each pattern to settle.
- Recovers the 4-bit hex value shown on each digit and flags illegal patterns.
- Used as a loopback checker on the board and in system benches; sits beside the display pins, reads them, never drives them.

Parameters:
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a pattern is committed; legal range 2..65535.
- TIMEOUT_CYCLES, 100000: cycles without a commit to a digit before that digit's valid is cleared; legal range > STABLE_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- seg_in  input  7  segment lines {g,f,e,d,c,b,a}; active low (0 = lit).
- an_in  input  2  anode enables; active low; bit0 = digit0, bit1 = digit1.
- clear  input  1  one-cycle pulse; clears bad_pattern.
- digit0  output  4  last committed hex value, digit0.
- digit1  output  4  last committed hex value, digit1.
- digit_valid  output  2  per digit: 1 = digit holds a legal committed value.
- update  output  1  one-cycle pulse when any digitN or digit_valid bit changes.
- bad_pattern  output  1  sticky; set on commit of an illegal non-blank pattern.
- bad_seg  output  7  raw seg of the most recent illegal pattern.

Behaviour:
- Reset: all outputs 0; synchronizer flops 1 (idle bus); counters 0; FSM in SETTLE.
- Input path: {an_in, seg_in} pass through a 2-flop synchronizer giving sample s.
- Stability counter cnt:
  - If s != previous s: cnt <= 1 and FSM -> SETTLE.
  - Else cnt increments, saturating at STABLE_CYCLES.
- FSM states:
  - SETTLE: when cnt reaches STABLE_CYCLES, perform exactly one commit and go to HOLD.
  - HOLD: no further commits until s changes, then back to SETTLE.
- Commit rules:
  - an = 11 (none lit) or 00 (both lit): no action.
  - Exactly one anode low selects digit N.
  - seg matches the legal table: digitN <= value; digit_valid[N] <= 1.
  - seg = 1111111 (blank): digit_valid[N] <= 0; digitN unchanged; no error.
  - Any other seg: digit_valid[N] <= 0; bad_pattern <= 1; bad_seg <= seg.
- Legal table (hex: seg):
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
  - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
  - 8: 0000000, 9: 0011000, A: 0001000, b: 0000011
  - C: 1000110, d: 0100001, E: 0000110, F: 0001110
- Latency: pins held constant from edge k produce updated outputs visible after edge k+STABLE_CYCLES+3 (2 sync + STABLE_CYCLES settle + 1 output register).
- update:
  - Asserted in the same cycle the changed outputs first appear.
  - Not asserted when a commit rewrites an identical value/valid.
- Timeout:
  - Per-digit counter; reset to 0 on any commit to that digit, otherwise increments and saturates.
  - On reaching TIMEOUT_CYCLES with digit_valid[N] = 1: clear digit_valid[N] and pulse update.
  - A commit and a timeout for the same digit in the same cycle: the commit wins.
- clear and a bad commit in the same cycle: bad_pattern stays 1 and bad_seg updates.
- Multiplex glitches: patterns shorter than STABLE_CYCLES never commit, including ghost overlaps during anode switching.
- Reset mid-settle: all progress is discarded; the pattern must re-settle fully after reset deasserts.
- Only the 2-bit anode decode is specific to two digits.

Test Plan:
- STABLE_CYCLES=4. Reset, then drive an_in=10, seg_in=0110000 held -> exactly 7 cycles later digit0=3, digit_valid=01, update high for 1 cycle; no further update while held.
- Alternate an_in=10/seg=0010010 and an_in=01/seg=0000110, 20 cycles each -> digit0=5, digit1=E, digit_valid=11; update pulses only on the first commit per digit.
- an_in=10, seg=0011001 held for 3 cycles, then seg=1111001 held -> digit0 never shows 4; shows 1 after the settle time.
- an_in=01, seg=1010101 held -> bad_pattern=1, bad_seg=1010101, digit_valid[1]=0. Pulse clear with the bus idle (an=11) -> bad_pattern=0. Blank 1111111 on digit1 -> valid cleared, bad_pattern stays 0.
- TIMEOUT_CYCLES=50: commit digit0=A, then an_in=11 -> digit_valid[0] drops exactly 50 cycles after the commit, with an update pulse.
- Assert reset for 1 cycle midway through a settle, and again while HOLD has digit_valid=11 -> all outputs 0 the cycle after the reset edge; a new commit occurs only after STABLE_CYCLES+3 cycles from reset deassertion.
